// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU
//   in EX. Multiplies use LSB-first shift-add; divides use restoring division.
//   Operands are reduced to magnitudes on entry and the sign is applied in a
//   FIXUP cycle. Divide-by-zero, signed overflow and non-M codes complete
//   straight from IDLE into DONE.
//
//   Optional feature (compile-time macro): MULDIV_FAST_MUL_EN
//     defined   : all four multiplies finish in one cycle (IDLE -> DONE)
//     undefined : multiplies use the 34-cycle iterative path
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      request a new operation (only sampled in IDLE)
//   flush      abort; returns to IDLE, result untouched
//   alusel     5-bit ALU_* operation code (M codes listed below)
//   op_a       rs1: dividend / multiplicand
//   op_b       rs2: divisor / multiplier
//   busy       registered, high while CALC/FIXUP is in progress
//   done       registered one-cycle pulse, result valid in this cycle
//   result     registered result, held until rewritten
//   dbg_state  current FSM state (IDLE=0, CALC=1, FIXUP=2, DONE=3)
//
// Handshake: start is a request that is accepted on a rising edge only while
//   the unit is in IDLE and flush is low; once accepted, exactly one done
//   pulse follows unless a flush or reset intervenes. There is no
//   back-pressure on done: the consumer must capture result in that cycle.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      alusel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  // ALU_* codes for the M extension (mirror of defines.v)
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q,  state_d;
  logic [4:0]        cnt_q,    cnt_d;
  logic [4:0]        op_q,     op_d;
  logic [XLEN-1:0]   opnd_q,   opnd_d;   // |multiplicand| or |divisor|
  logic [2*XLEN-1:0] acc_q,    acc_d;    // {hi, lo} working register
  logic              neg_q,    neg_d;    // final result must be negated
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
  logic            is_mul, is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;

  assign is_mul   = (alusel >= ALU_MUL) && (alusel <= ALU_MULHU);
  assign is_div   = (alusel >= ALU_DIV) && (alusel <= ALU_REMU);
  // MUL only keeps the low half, which is identical for signed and unsigned
  assign a_signed = (alusel == ALU_MULH) || (alusel == ALU_MULHSU) ||
                    (alusel == ALU_DIV)  || (alusel == ALU_REM);
  assign b_signed = (alusel == ALU_MULH) || (alusel == ALU_DIV) ||
                    (alusel == ALU_REM);
  assign a_neg    = a_signed & op_a[XLEN-1];
  assign b_neg    = b_signed & op_b[XLEN-1];
  // INT_MIN negates to itself, which is still the right unsigned magnitude
  assign abs_a    = a_neg ? -op_a : op_a;
  assign abs_b    = b_neg ? -op_b : op_b;

`ifdef MULDIV_FAST_MUL_EN
  // Signed 33x33 multiply, expressed as sign-extended 64x64 truncated to 64
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_p;
  logic [XLEN-1:0]          fast_res;
  assign fast_a   = {{XLEN{(alusel != ALU_MULHU) & op_a[XLEN-1]}}, op_a};
  assign fast_b   = {{XLEN{((alusel == ALU_MUL) || (alusel == ALU_MULH)) & op_b[XLEN-1]}}, op_b};
  assign fast_p   = fast_a * fast_b;
  assign fast_res = (alusel == ALU_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`endif

  // Operations that finish directly from IDLE with a fixed result
  logic            spec_hit;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    spec_hit = 1'b0;
    spec_res = '0;
    if (!is_mul && !is_div) begin
      spec_hit = 1'b1;
      spec_res = '0;
    end else if (is_div && (op_b == '0)) begin
      spec_hit = 1'b1;
      spec_res = ((alusel == ALU_DIV) || (alusel == ALU_DIVU)) ? '1 : op_a;
    end else if (((alusel == ALU_DIV) || (alusel == ALU_REM)) &&
                 (op_a == INT_MIN) && (op_b == '1)) begin
      spec_hit = 1'b1;
      spec_res = (alusel == ALU_DIV) ? INT_MIN : '0;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (is_mul) begin
      spec_hit = 1'b1;
      spec_res = fast_res;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------------
  logic              op_mul_q;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_rem_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  assign op_mul_q = (op_q >= ALU_MUL) && (op_q <= ALU_MULHU);

  // Shift-add: the multiplier sits in acc low half and is consumed LSB first
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                             : {1'b0, acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1:1]};

  // Restoring divide: acc = {remainder, dividend/quotient}. Since the
  // remainder is always below the divisor, a 33-bit subtract suffices and
  // its MSB is set exactly when the trial subtraction would go negative.
  assign div_rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff   = div_rem_sh - {1'b0, opnd_q};
  assign div_next   = div_diff[XLEN]
                    ? {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                    : {div_diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};

  // ---------------------------------------------------------------------------
  // Sign fixup and result selection
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (op_q)
      ALU_MUL:                         fix_res = prod_fix[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:               fix_res = quo_fix;
      ALU_REM, ALU_REMU:               fix_res = rem_fix;
      default:                         fix_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d   = alusel;
            // remainder follows the dividend; everything else is a XOR b
            neg_d  = (alusel == ALU_REM) ? a_neg : (a_neg ^ b_neg);
            opnd_d = is_mul ? abs_a : abs_b;
            acc_d  = {{XLEN{1'b0}}, (is_mul ? abs_b : abs_a)};
            if (spec_hit) begin
              result_d = spec_res;
              state_d  = S_DONE;
            end else begin
              cnt_d   = 5'd31;
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = op_mul_q ? mul_next : div_next;
          if (cnt_q == 5'd0) begin
            state_d = S_FIXUP;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        S_FIXUP: begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    busy_d = (state_d == S_CALC) || (state_d == S_FIXUP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, beside the single-cycle ALU. It takes the 5-bit `alusel` code from the ALU control unit for the eight M-extension operations (`ALU_MUL` through `ALU_REMU`) and computes the result over multiple cycles. While it runs, it asserts `busy` so the hazard unit holds IF/ID/EX. A one-cycle `done` pulse tells the EX/MEM register to capture `result`.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous reset, active-low. One clock; reset is synchronous and active-low.
- `start` input 1: request a new operation. Sampled only in IDLE.
- `flush` input 1: abort the current operation (branch mispredict or pipeline flush).
- `alusel` input 5: operation code from the ALU control unit. Uses the `ALU_*` defines in defines.v.
- `op_a` input 32: rs1 value. Dividend or multiplicand.
- `op_b` input 32: rs2 value. Divisor or multiplier.
- `busy` output 1: high from the cycle after `start` is accepted until the cycle `done` is asserted, exclusive of that cycle.
- `done` output 1: one-cycle pulse; `result` is valid in this cycle.
- `result` output 32: final value. Held until the next accepted `start`.

## Operation
- FSM states: IDLE, CALC, FIXUP, DONE.
- **IDLE**
  - `start=1` latches `alusel`, `op_a`, `op_b`.
  - Signed ops (MULH, DIV, REM; MULHSU on `op_a` only) store absolute values and record the result sign.
  - Default transition: to CALC, with the iteration counter set to 31.
- **Special cases** go IDLE→DONE directly with the fixed result:
  - DIV/DIVU with `op_b=0`: quotient = 0xFFFFFFFF.
  - REM/REMU with `op_b=0`: remainder = `op_a`.
  - DIV with `op_a=0x80000000`, `op_b=0xFFFFFFFF`: quotient = 0x80000000.
  - REM with the same operands: remainder = 0.
  - `alusel` not an M code: `result`=0.
- **CALC** runs 32 iterations, one bit per cycle. The counter decrements each cycle; at 0 → FIXUP.
  - Multiply: shift-add into a 64-bit accumulator, with the multiplier LSB first.
  - Divide: restoring division. A 33-bit partial-remainder subtract per cycle; the quotient bit shifts in at the LSB.
- **FIXUP** → DONE.
  - Result selection: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits.
  - Negate the 64-bit product if its sign is negative.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign of the dividend.
  - Write `result`.
- **DONE**: `done`=1 for one cycle, then → IDLE. A `start` during DONE is ignored; the pipeline re-issues it.
- `start` in CALC/FIXUP/DONE: ignored.
- `flush`:
  - Takes priority over everything except `rst_n`.
  - In any state, the next state is IDLE, `busy`=0, `done`=0, and `result` is unchanged.
  - `flush` and `start` both high in IDLE: the start is dropped.
- Width rules:
  - MULHSU treats `op_b` as unsigned. The sign is taken from `op_a` only.
  - All negation is two's complement at full width: 64-bit for products, 32-bit for quotient and remainder.

## Timing
- Reset (`rst_n=0` at a rising edge) is effective mid-operation: state=IDLE, counter=0, `busy`=0, `done`=0, `result`=0.
- Normal op with `start` accepted at edge N:
  - `busy`=1 in cycles N+1..N+33, where the cycle after edge k is cycle k.
  - CALC occupies cycles N+1..N+32.
  - FIXUP is cycle N+33.
  - `done`=1 in cycle N+34 with `busy`=0.
  - Total latency: 34 cycles.
- Special case with `start` at edge N: `done`=1 in cycle N+1; `busy` stays 0.
- Back-to-back: the earliest next accepted `start` is the edge ending the DONE cycle plus one. That is, throughput is one operation per 35 cycles.
- Outputs `busy`, `done`, and `result` are registered. No combinational path runs from inputs to outputs.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU compute the 64-bit product in one cycle using a signed 33×33 multiply, and go IDLE→DONE.
  - `done` is asserted in cycle N+1 and `busy` stays 0. Division is unchanged.
- Not defined: every multiply uses the 34-cycle iterative path above.

## Test plan
- Reset: `rst_n`=0 for 2 cycles while in CALC → `busy`=0, `done`=0, `result`=0. The next `start` behaves normally.
- DIV `op_a`=-7 (0xFFFFFFF9), `op_b`=2 → quotient 0xFFFFFFFD (-3). REM with the same operands → 0xFFFFFFFF (-1). Each has `done` at cycle N+34 and `busy` high for 33 cycles.
- Division specials:
  - DIVU `op_b`=0, `op_a`=0x1234 → 0xFFFFFFFF.
  - REM `op_b`=0, `op_a`=0x1234 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
  - All four: `done` at N+1.
- Multiply: MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MUL 0xFFFFFFFF × 3 → 0xFFFFFFFD. Latency is 34 cycles, or 1 cycle with `MULDIV_FAST_MUL_EN`.
- Flush and start handling:
  - `flush` at CALC iteration 10 → IDLE next cycle, no `done`, `result` keeps its previous value.
  - A `start` pulsed during CALC is ignored, and `result` matches the first operation.
